// File: rtl/bsg_gatestack_pkg.sv
// Shared types and helpers for the gatestack strobe generator.
package bsg_gatestack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Phase counters must hold the largest (phase length - 1); never narrower than one bit.
  function automatic int cnt_width(input int setup_c, input int pulse_c, input int hold_c);
    int m;
    m = setup_c;
    if (pulse_c > m) m = pulse_c;
    if (hold_c > m) m = hold_c;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bsg_gatestack_phase_counter.sv
// Loadable down-counter with zero flag; sequences the setup, pulse and hold phases.
module bsg_gatestack_phase_counter #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [width_p-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - width_p'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_gatestack_strobe_gen.sv
// Turns valid/ready lane writes into per-lane data plus glitch-free clock strobes for a gatestack.
// Optional readback register enabled by defining BSG_GATESTACK_STROBE_SHADOW_EN.
module bsg_gatestack_strobe_gen
  import bsg_gatestack_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int setup_cycles_p = 1,
  parameter int pulse_cycles_p = 1,
  parameter int hold_cycles_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] mask_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic [width_p-1:0] strobe_o,
  output logic               busy_o
`ifdef BSG_GATESTACK_STROBE_SHADOW_EN
  ,
  output logic [width_p-1:0] shadow_o
`endif
);

  if ((setup_cycles_p < 1) || (pulse_cycles_p < 1) || (hold_cycles_p < 1)) begin : gen_bad_params
    $error("bsg_gatestack_strobe_gen: setup/pulse/hold cycle counts must all be >= 1");
  end

  localparam int cnt_w_lp = cnt_width(setup_cycles_p, pulse_cycles_p, hold_cycles_p);
  localparam logic [cnt_w_lp-1:0] setup_ld_lp = cnt_w_lp'(setup_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] pulse_ld_lp = cnt_w_lp'(pulse_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] hold_ld_lp  = cnt_w_lp'(hold_cycles_p - 1);

  state_e             state_q, state_d;
  logic [width_p-1:0] mask_q, mask_d;
  logic [width_p-1:0] data_q, data_d;
  logic [width_p-1:0] strobe_q, strobe_d;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [cnt_w_lp-1:0] cnt_val;
  logic               pulse_done;

  bsg_gatestack_phase_counter #(.width_p(cnt_w_lp)) phase_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = ~ready_o;
  assign data_o   = data_q;
  assign strobe_o = strobe_q;

  // Data only moves on the accept edge, strobes only on phase edges, so the two never change together.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    data_d     = data_q;
    strobe_d   = strobe_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = '0;
    pulse_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          mask_d   = mask_i;
          data_d   = (data_q & ~mask_i) | (data_i & mask_i);
          strobe_d = '0;
          cnt_load = 1'b1;
          cnt_val  = setup_ld_lp;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          strobe_d = mask_q;
          cnt_load = 1'b1;
          cnt_val  = pulse_ld_lp;
          state_d  = PULSE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          strobe_d   = '0;
          cnt_load   = 1'b1;
          cnt_val    = hold_ld_lp;
          pulse_done = 1'b1;
          state_d    = HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      data_q   <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef BSG_GATESTACK_STROBE_SHADOW_EN
  logic [width_p-1:0] shadow_q, shadow_d;

  // Mirrors what the gatestack latched on the strobe that just finished.
  always_comb begin
    shadow_d = shadow_q;
    if (pulse_done) shadow_d = (shadow_q & ~mask_q) | (data_q & mask_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) shadow_q <= '0;
    else         shadow_q <= shadow_d;
  end

  assign shadow_o = shadow_q;
`else
  logic unused_pulse_done;
  assign unused_pulse_done = pulse_done;
`endif

endmodule

// File: tb/tb_bsg_gatestack_strobe_gen.sv
// Directed and randomised checks of the gatestack strobe generator, default and stretched timing.
module tb_bsg_gatestack_strobe_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0;
  logic [31:0] mask = '0;
  logic [31:0] data = '0;
  logic        ready, busy;
  logic [31:0] data_o, strobe;

  logic        v2 = 1'b0;
  logic [31:0] mask2 = '0;
  logic [31:0] data2 = '0;
  logic        ready2, busy2;
  logic [31:0] data2_o, strobe2;

`ifdef BSG_GATESTACK_STROBE_SHADOW_EN
  logic [31:0] shadow, shadow2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bsg_gatestack_strobe_gen dut (
    .clk_i(clk), .reset_i(rst), .v_i(v), .mask_i(mask), .data_i(data),
    .ready_o(ready), .data_o(data_o), .strobe_o(strobe), .busy_o(busy)
`ifdef BSG_GATESTACK_STROBE_SHADOW_EN
    , .shadow_o(shadow)
`endif
  );

  bsg_gatestack_strobe_gen #(.width_p(32), .setup_cycles_p(2), .pulse_cycles_p(3), .hold_cycles_p(2)) dut2 (
    .clk_i(clk), .reset_i(rst), .v_i(v2), .mask_i(mask2), .data_i(data2),
    .ready_o(ready2), .data_o(data2_o), .strobe_o(strobe2), .busy_o(busy2)
`ifdef BSG_GATESTACK_STROBE_SHADOW_EN
    , .shadow_o(shadow2)
`endif
  );

  // Gatestack model: each lane captures data_o on the rising edge of its strobe.
  logic [31:0] gs;
  for (genvar gi = 0; gi < 32; gi++) begin : gen_gs
    logic lane_q;
    always @(posedge strobe[gi] or posedge rst) begin
      if (rst) lane_q <= 1'b0;
      else     lane_q <= data_o[gi];
    end
    assign gs[gi] = lane_q;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on the default-timing DUT, checked cycle by cycle (accept at e0, strobe after e1).
  task automatic do_req(input logic [31:0] m, input logic [31:0] d, input logic [31:0] exp_d);
    check("pre_ready", 32'(ready), 32'(1));
    v = 1'b1; mask = m; data = d;
    @(posedge clk); #1;
    v = 1'b0;
    check("setup_data", data_o, exp_d);
    check("setup_strobe", strobe, 32'h0);
    check("setup_ready", 32'(ready), 32'(0));
    check("setup_busy", 32'(busy), 32'(1));
    @(posedge clk); #1;
    check("pulse_strobe", strobe, m);
    check("pulse_data", data_o, exp_d);
    @(posedge clk); #1;
    check("hold_strobe", strobe, 32'h0);
    check("hold_ready", 32'(ready), 32'(0));
    @(posedge clk); #1;
    check("idle_ready", 32'(ready), 32'(1));
    check("idle_data", data_o, exp_d);
    $display("req mask=%h data=%h -> data_o=%h", m, d, data_o);
  endtask

  typedef struct {
    logic [31:0] mask;
    logic [31:0] data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] exp_d, m, d, prev_data;
    int busy_cyc, n_acc, last_acc, run;
    logic prev_ready;

    vecs[0] = '{32'hF0F0_0000, 32'hFFFF_FFFF, 32'hF0F0_0000};
    vecs[1] = '{32'h0000_0001, 32'h0000_0001, 32'hF0F0_0001};
    vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hF0F0_0001};
    vecs[3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
    vecs[4] = '{32'h0000_FFFF, 32'h0000_0000, 32'h1234_0000};
    vecs[5] = '{32'h8000_0001, 32'hFFFF_FFFF, 32'h9234_0001};

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_data", data_o, 32'h0);
    check("rst_strobe", strobe, 32'h0);
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));

    foreach (vecs[i]) do_req(vecs[i].mask, vecs[i].data, vecs[i].exp_data);

    // Reset asserted mid-PULSE must drop strobes without waiting for a clock edge.
    v = 1'b1; mask = 32'hFFFF_FFFF; data = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    v = 1'b0;
    @(posedge clk); #1;
    check("midpulse_strobe_hi", strobe, 32'hFFFF_FFFF);
    #2 rst = 1'b1;
    #1;
    check("midpulse_rst_strobe", strobe, 32'h0);
    check("midpulse_rst_data", data_o, 32'h0);
    check("midpulse_rst_ready", 32'(ready), 32'(1));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Random requests against the gatestack model.
    exp_d = '0;
    for (int n = 0; n < 100; n++) begin
      m = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      d = $urandom;
      exp_d = (exp_d & ~m) | (d & m);
      check("rand_pre_ready", 32'(ready), 32'(1));
      v = 1'b1; mask = m; data = d;
      @(posedge clk); #1;
      v = 1'b0;
      busy_cyc = 0;
      while (!ready && busy_cyc < 20) begin
        busy_cyc++;
        @(posedge clk); #1;
      end
      check("rand_busy_cycles", 32'(busy_cyc), 32'(3));
      check("rand_data", data_o, exp_d);
      check("rand_gatestack", gs, exp_d);
`ifdef BSG_GATESTACK_STROBE_SHADOW_EN
      check("rand_shadow", shadow, exp_d);
`endif
      $display("rand %0d mask=%h data=%h gs=%h", n, m, d, gs);
    end

    // Stretched timing with v held high: one accept every 1+2+3+2 cycles.
    v2 = 1'b1; mask2 = 32'hFFFF_FFFF;
    prev_ready = ready2; prev_data = data2_o;
    n_acc = 0; last_acc = 0; run = 0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      data2 = $urandom;
      @(posedge clk); #1;
      if (prev_ready) begin
        if (n_acc > 0) check("b2b_interval", 32'(cyc - last_acc), 32'(8));
        check("b2b_accept_data", data2_o, data2);
        $display("b2b accept cyc=%0d data_o=%h", cyc, data2_o);
        last_acc = cyc;
        n_acc++;
      end
      if (strobe2 != 0) begin
        check("b2b_data_stable", data2_o, prev_data);
        check("b2b_strobe_mask", strobe2, 32'hFFFF_FFFF);
        run++;
      end else if (run != 0) begin
        check("b2b_pulse_len", 32'(run), 32'(3));
        run = 0;
      end
      prev_ready = ready2;
      prev_data = data2_o;
    end
    v2 = 1'b0;
    check("b2b_accept_count", 32'(n_acc), 32'(9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
